// File: rtl/mux1hot_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux1hot_arb_pkg
// Shared types and helpers for the one-hot round-robin arbiters.
//   arb_state_t : arbiter state (IDLE / BUSY)
//   onehot2idx  : one-hot vector (up to MAX_N bits) -> binary index
//   rr_pick     : behavioural round-robin pick, first set bit after ptr,
//                 wrapping modulo n; returns a one-hot vector
// ---------------------------------------------------------------------------
package mux1hot_arb_pkg;

  localparam int MAX_N = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // OR of the indices of all set bits; exact for a one-hot or zero input.
  function automatic logic [3:0] onehot2idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [MAX_N-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                               input logic [3:0]       ptr,
                                               input int               n);
    logic [MAX_N-1:0] res;
    int               idx;
    res = '0;
    for (int k = 1; k <= n; k++) begin
      idx = (int'(ptr) + k) % n;
      if (res == '0 && req[idx]) res[idx] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux1hot.sv
// ---------------------------------------------------------------------------
// mux1hot
// AND-OR one-hot multiplexer.
//   i_sel  : one-hot select (zero selects nothing, output is 0)
//   i_data : N packed words, word i at [i*WIDTH +: WIDTH]
//   o_data : selected word
// ---------------------------------------------------------------------------
module mux1hot #(
  parameter int N     = 8,
  parameter int WIDTH = 32
) (
  input  logic [N-1:0]       i_sel,
  input  logic [N*WIDTH-1:0] i_data,
  output logic [WIDTH-1:0]   o_data
);

  logic [WIDTH-1:0] w_terms [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_term
    assign w_terms[gi] = i_data[gi*WIDTH +: WIDTH] & {WIDTH{i_sel[gi]}};
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) o_data = o_data | w_terms[i];
  end

endmodule

// File: rtl/rr_pick_onehot.sv
// ---------------------------------------------------------------------------
// rr_pick_onehot
// Combinational round-robin pick: rotate the request vector so that the
// requester after i_ptr sits at bit 0, isolate the lowest set bit, then
// rotate the result back into requester order.
//   i_req   : request vector, one bit per requester
//   i_ptr   : index of the previous winner (search starts at i_ptr+1)
//   o_grant : one-hot winner, zero when no request
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_pick_onehot #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic           o_any
);

  logic [IDW-1:0] w_start;
  logic [N-1:0]   w_rot;
  logic [N-1:0]   w_first;

  assign w_start = (i_ptr == IDW'(N - 1)) ? '0 : i_ptr + 1'b1;

  // One extra bit so gi + start (or gi + N - start) never overflows before
  // the single conditional subtract that reduces it modulo N.
  for (genvar gi = 0; gi < N; gi++) begin : g_rotate
    logic [IDW:0]   w_fwd_sum;
    logic [IDW-1:0] w_fwd_idx;
    logic [IDW:0]   w_back_sum;
    logic [IDW-1:0] w_back_idx;

    assign w_fwd_sum  = (IDW+1)'(gi) + {1'b0, w_start};
    assign w_fwd_idx  = (w_fwd_sum >= (IDW+1)'(N)) ? IDW'(w_fwd_sum - (IDW+1)'(N))
                                                   : IDW'(w_fwd_sum);
    assign w_rot[gi]  = i_req[w_fwd_idx];

    assign w_back_sum = (IDW+1)'(gi) + (IDW+1)'(N) - {1'b0, w_start};
    assign w_back_idx = (w_back_sum >= (IDW+1)'(N)) ? IDW'(w_back_sum - (IDW+1)'(N))
                                                    : IDW'(w_back_sum);
    assign o_grant[gi] = w_first[w_back_idx];
  end

  // Two's-complement trick isolates the lowest set bit.
  assign w_first = w_rot & (~w_rot + 1'b1);
  assign o_any   = |i_req;

endmodule

// File: rtl/mux1hot_rr_arb.sv
// ---------------------------------------------------------------------------
// mux1hot_rr_arb
// Round-robin burst arbiter: shares one valid/ready output among N
// requesters, holding each grant until the beat flagged last (or until
// MAX_BEATS accepted beats when MAX_BEATS != 0). Datapath is purely
// combinational; only grant, pointer and beat count are registered.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid/in_last  : per-requester valid and last flags
//   in_data           : requester i at [i*WIDTH +: WIDTH]
//   in_ready          : per-requester ready, one-hot or zero
//   out_valid/out_data/out_last/out_id : selected channel
//   out_ready         : sink ready
//   grant             : registered one-hot grant (mux select)
// ---------------------------------------------------------------------------
module mux1hot_rr_arb
  import mux1hot_arb_pkg::*;
#(
  parameter int N         = 8,
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 0,
  parameter int IDW       = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [IDW-1:0]     out_id,
  input  logic               out_ready,
  output logic [N-1:0]       grant
);

  localparam int              BW         = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1);
  localparam bit              LIMIT_EN   = (MAX_BEATS != 0);
  localparam logic [BW-1:0]   BEAT_LIMIT = (MAX_BEATS == 0) ? '0 : BW'(MAX_BEATS - 1);

  arb_state_t     r_state, w_state_next;
  logic [N-1:0]   r_grant, w_grant_next;
  logic [IDW-1:0] r_last_win, w_last_win_next;
  logic [BW-1:0]  r_beats, w_beats_next;

  logic           w_busy;
  logic [N-1:0]   w_pick;
  logic           w_pick_any;
  logic [IDW-1:0] w_pick_idx;
  logic [IDW-1:0] w_gidx;
  logic [WIDTH-1:0] w_mux_data;
  logic           w_hs;
  logic           w_release;

  rr_pick_onehot #(.N(N), .IDW(IDW)) u_pick (
    .i_req   (in_valid),
    .i_ptr   (r_last_win),
    .o_grant (w_pick),
    .o_any   (w_pick_any)
  );

  mux1hot #(.N(N), .WIDTH(WIDTH)) u_mux (
    .i_sel  (r_grant),
    .i_data (in_data),
    .o_data (w_mux_data)
  );

  assign w_busy     = (r_state == BUSY);
  assign w_pick_idx = IDW'(onehot2idx(MAX_N'(w_pick)));
  assign w_gidx     = IDW'(onehot2idx(MAX_N'(r_grant)));

  // Outputs are forced to zero outside BUSY so nothing stale leaks out.
  assign out_valid = w_busy & |(r_grant & in_valid);
  assign out_last  = w_busy & |(r_grant & in_last);
  assign out_data  = w_busy ? w_mux_data : '0;
  assign out_id    = w_busy ? w_gidx : '0;
  assign in_ready  = w_busy ? (r_grant & {N{out_ready}}) : '0;
  assign grant     = r_grant;

  assign w_hs      = out_valid & out_ready;
  assign w_release = w_hs & (out_last | (LIMIT_EN && (r_beats == BEAT_LIMIT)));

  always_comb begin
    w_state_next    = r_state;
    w_grant_next    = r_grant;
    w_last_win_next = r_last_win;
    w_beats_next    = r_beats;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_next    = BUSY;
          w_grant_next    = w_pick;
          w_last_win_next = w_pick_idx;
          w_beats_next    = '0;
        end else begin
          w_grant_next = '0;
        end
      end
      BUSY: begin
        if (w_release) begin
          // Re-arbitrate in the releasing cycle: zero-bubble hand-over.
          if (w_pick_any) begin
            w_grant_next    = w_pick;
            w_last_win_next = w_pick_idx;
            w_beats_next    = '0;
          end else begin
            w_state_next = IDLE;
            w_grant_next = '0;
            w_beats_next = '0;
          end
        end else if (w_hs) begin
          w_beats_next = r_beats + 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_last_win <= IDW'(N - 1);  // requester 0 wins the first arbitration
      r_beats    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_grant    <= w_grant_next;
      r_last_win <= w_last_win_next;
      r_beats    <= w_beats_next;
    end
  end

endmodule

// File: tb/tb_mux1hot_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux1hot_rr_arb
// Directed bench for mux1hot_rr_arb. Two instances share the stimulus:
// u_dut (no beat limit) and u_dut_mb (MAX_BEATS = 4, used for the
// forced-release scenario).
// ---------------------------------------------------------------------------
module tb_mux1hot_rr_arb;

  localparam int N = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic           out_ready;

  logic [N-1:0]   in_ready_a,  in_ready_b;
  logic           out_valid_a, out_valid_b;
  logic [W-1:0]   out_data_a,  out_data_b;
  logic           out_last_a,  out_last_b;
  logic [2:0]     out_id_a,    out_id_b;
  logic [N-1:0]   grant_a,     grant_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux1hot_rr_arb #(.N(N), .WIDTH(W), .MAX_BEATS(0)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready_a),
    .out_valid (out_valid_a),
    .out_data  (out_data_a),
    .out_last  (out_last_a),
    .out_id    (out_id_a),
    .out_ready (out_ready),
    .grant     (grant_a)
  );

  mux1hot_rr_arb #(.N(N), .WIDTH(W), .MAX_BEATS(4)) u_dut_mb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_last  (out_last_b),
    .out_id    (out_id_b),
    .out_ready (out_ready),
    .grant     (grant_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    in_data[idx*W +: W] = val;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Backpressure / valid-gap table
  bit rdy4 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  bit v4   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  // Forced release: expected granted id per cycle
  int exp_id5 [11] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1};

  initial begin
    int bp;
    int p1;
    bit r2_done;

    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // ---------------- Reset with all requesters valid ----------------
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("rst grant",     32'(grant_a),     32'h0);
      check_eq("rst in_ready",  32'(in_ready_a),  32'h0);
      check_eq("rst out_valid", 32'(out_valid_a), 32'h0);
      check_eq("rst out_id",    32'(out_id_a),    32'h0);
      check_eq("rst out_data",  out_data_a,       32'h0);
    end
    for (int i = 0; i < N; i++) set_data(i, 32'hA000_0000 + 32'(i));
    in_last = '1;
    rst_n   = 1'b1;
    step();
    check_eq("post-rst grant", 32'(grant_a), 32'h01);

    // ---------------- Round-robin fairness ----------------
    for (int k = 0; k < 9; k++) begin
      #1;
      check_eq("rr out_id",    32'(out_id_a),    32'(k % 8));
      check_eq("rr out_valid", 32'(out_valid_a), 32'h1);
      check_eq("rr out_data",  out_data_a,       32'hA000_0000 + 32'(k % 8));
      check_eq("rr grant",     32'(grant_a),     32'h1 << (k % 8));
      step();
    end

    // ---------------- Burst hold ----------------
    do_reset();
    in_valid  = 8'b0000_1000;
    out_ready = 1'b1;
    set_data(5, 32'h500);
    step();
    for (int b = 1; b <= 4; b++) begin
      set_data(3, 32'h300 + 32'(b));
      in_last[3] = (b == 4);
      if (b == 2) in_valid[5] = 1'b1;
      #1;
      check_eq("burst out_id",   32'(out_id_a),   32'h3);
      check_eq("burst out_data", out_data_a,      32'h300 + 32'(b));
      check_eq("burst out_last", 32'(out_last_a), (b == 4) ? 32'h1 : 32'h0);
      check_eq("burst in_ready", 32'(in_ready_a), 32'h08);
      step();
    end
    #1;
    check_eq("burst next id",   32'(out_id_a), 32'h5);
    check_eq("burst next grant", 32'(grant_a), 32'h20);
    check_eq("burst next data", out_data_a,    32'h500);

    // ---------------- Backpressure and valid gap ----------------
    do_reset();
    in_valid  = 8'b0001_0100;
    set_data(4, 32'h400);
    step();
    bp = 0;
    for (int c = 0; c < 7; c++) begin
      out_ready   = rdy4[c];
      in_valid[2] = v4[c];
      set_data(2, 32'h200 + 32'(bp));
      in_last[2]  = (bp == 2);
      #1;
      check_eq("bp grant",     32'(grant_a),     32'h04);
      check_eq("bp in_ready",  32'(in_ready_a),  rdy4[c] ? 32'h04 : 32'h0);
      check_eq("bp out_valid", 32'(out_valid_a), 32'(v4[c]));
      if (v4[c]) check_eq("bp out_data", out_data_a, 32'h200 + 32'(bp));
      if (rdy4[c] && v4[c]) bp++;
      step();
    end
    #1;
    check_eq("bp next id",    32'(out_id_a), 32'h4);
    check_eq("bp next grant", 32'(grant_a),  32'h10);

    // ---------------- Forced release (MAX_BEATS = 4) ----------------
    do_reset();
    in_valid  = 8'b0000_0110;
    in_last   = 8'b0000_0100;
    out_ready = 1'b1;
    step();
    p1      = 0;
    r2_done = 1'b0;
    for (int c = 0; c < 11; c++) begin
      in_valid[2] = !r2_done;
      set_data(1, 32'h100 + 32'(p1));
      set_data(2, 32'h2AA);
      #1;
      check_eq("force out_id",   32'(out_id_b), 32'(exp_id5[c]));
      check_eq("force out_data", out_data_b,
               (exp_id5[c] == 1) ? 32'h100 + 32'(p1) : 32'h2AA);
      step();
      if (exp_id5[c] == 1) p1++;
      else r2_done = 1'b1;
    end

    // ---------------- Wrap and single requester ----------------
    do_reset();
    in_valid  = 8'b1000_0000;
    in_last   = '1;
    out_ready = 1'b1;
    set_data(7, 32'h777);
    set_data(0, 32'h0F0);
    step();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) in_valid[0] = 1'b1;
      #1;
      check_eq("wrap out_id",    32'(out_id_a),    32'h7);
      check_eq("wrap out_valid", 32'(out_valid_a), 32'h1);
      check_eq("wrap out_data",  out_data_a,       32'h777);
      step();
    end
    #1;
    check_eq("wrap then 0 id",    32'(out_id_a), 32'h0);
    check_eq("wrap then 0 data",  out_data_a,    32'h0F0);
    step();
    #1;
    check_eq("wrap back to 7 id", 32'(out_id_a), 32'h7);
    check_eq("wrap back grant",   32'(grant_a),  32'h80);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
